// File: rtl/if_stage_if.sv
// ----------------------------------------------------------------------------
// if_stage_if -- instruction memory fetch bus between the IF stage and imem.
//
// Handshake: the IF stage raises imem_req with a word-aligned imem_addr and
// holds both stable until a cycle in which imem_ready is 1. In that cycle
// imem_rdata carries the instruction word and is consumed by the requester.
// At most one request is outstanding at a time.
//
// Signals:
//   imem_req    IF -> mem  fetch request
//   imem_addr   IF -> mem  fetch address (32, word aligned)
//   imem_ready  mem -> IF  response valid this cycle
//   imem_rdata  mem -> IF  fetched instruction word (32)
// Modports:
//   master  used by if_stage
//   slave   used by the instruction memory
// ----------------------------------------------------------------------------
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/if_stage.sv
// ----------------------------------------------------------------------------
// if_stage -- instruction fetch stage with IF/ID pipeline register.
//
// Fetches one instruction per cycle from a ready/valid instruction memory,
// honours hazard stalls by parking a returned word in hold_instr, and handles
// redirects from ID (branch / jump / jump-register). A redirect that arrives
// while a fetch is still outstanding moves to DRAIN, where the stale response
// is thrown away before fetching from the newest target.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   stall                  hold IF/ID and PC (ignored when a redirect is present)
//   pc_sel[1:0]            00 seq, 01 npc_beq, 10 npc_j, 11 npc_jr
//   npc_beq/npc_j/npc_jr   redirect targets from ID
//   imem                   fetch bus (if_stage_if.master)
//   if_id_pc/pc4/instr     IF/ID register contents
//   if_id_valid            IF/ID holds a real instruction (0 = bubble)
//   dbg_state_o            current FSM state (FETCH=0, HOLD=1, DRAIN=2)
// ----------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [1:0]       pc_sel,
  input  logic [31:0]      npc_beq,
  input  logic [31:0]      npc_j,
  input  logic [31:0]      npc_jr,
  if_stage_if.master       imem,
  output logic [31:0]      if_id_pc,
  output logic [31:0]      if_id_pc4,
  output logic [31:0]      if_id_instr,
  output logic             if_id_valid,
  output logic [1:0]       dbg_state_o
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fa_q, fa_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] seq_addr;

  assign redirect = (pc_sel != 2'b00);
  // Targets are forced word aligned; pc_sel 00 never uses target.
  assign target   = (pc_sel == 2'b01) ? {npc_beq[31:2], 2'b00} :
                    (pc_sel == 2'b10) ? {npc_j[31:2],   2'b00} :
                                        {npc_jr[31:2],  2'b00};
  // Natural 32-bit wrap from FFFF_FFFC to 0.
  assign seq_addr = fa_q + 32'd4;

  // No request while parked in HOLD, and none while reset is held, so that a
  // reset aborts the outstanding fetch immediately.
  assign imem.imem_req  = !rst && (state_q != HOLD);
  assign imem.imem_addr = fa_q;

  assign if_id_pc    = pc_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_instr = instr_q;
  assign if_id_valid = valid_q;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d      = state_q;
    fa_d         = fa_q;
    pend_d       = pend_q;
    hold_instr_d = hold_instr_q;
    pc_d         = pc_q;
    pc4_d        = pc4_q;
    instr_d      = instr_q;
    valid_d      = valid_q;

    case (state_q)
      FETCH: begin
        if (imem.imem_ready) begin
          if (redirect) begin
            valid_d = 1'b0;
            fa_d    = target;
          end else if (stall) begin
            // Word arrived but ID cannot take it: park it.
            hold_instr_d = imem.imem_rdata;
            state_d      = HOLD;
          end else begin
            pc_d    = fa_q;
            pc4_d   = seq_addr;
            instr_d = imem.imem_rdata;
            valid_d = 1'b1;
            fa_d    = seq_addr;
          end
        end else begin
          if (redirect) begin
            // Request still in flight; its response must be dropped.
            valid_d = 1'b0;
            pend_d  = target;
            state_d = DRAIN;
          end else if (!stall) begin
            valid_d = 1'b0;
          end
        end
      end

      HOLD: begin
        if (redirect) begin
          valid_d = 1'b0;
          fa_d    = target;
          state_d = FETCH;
        end else if (!stall) begin
          pc_d    = fa_q;
          pc4_d   = seq_addr;
          instr_d = hold_instr_q;
          valid_d = 1'b1;
          fa_d    = seq_addr;
          state_d = FETCH;
        end
      end

      DRAIN: begin
        valid_d = 1'b0;
        if (imem.imem_ready) begin
          // Response discarded; the newest redirect target wins.
          fa_d    = redirect ? target : pend_q;
          state_d = FETCH;
        end else if (redirect) begin
          pend_d = target;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH;
      fa_q         <= RESET_PC;
      pend_q       <= RESET_PC;
      hold_instr_q <= 32'd0;
      pc_q         <= 32'd0;
      pc4_q        <= 32'd0;
      instr_q      <= 32'd0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fa_q         <= fa_d;
      pend_q       <= pend_d;
      hold_instr_q <= hold_instr_d;
      pc_q         <= pc_d;
      pc4_q        <= pc4_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [1:0]  pc_sel = 2'b00;
  logic [31:0] npc_beq = 32'd0;
  logic [31:0] npc_j = 32'd0;
  logic [31:0] npc_jr = 32'd0;
  logic [31:0] if_id_pc, if_id_pc4, if_id_instr;
  logic        if_id_valid;
  logic [1:0]  dbg_state;

  // Memory model: zero-wait (returns addr as data) or manually driven.
  logic        zw = 1'b1;
  logic        m_ready = 1'b0;
  logic [31:0] m_rdata = 32'd0;

  int checks = 0;
  int passed = 0;

  if_stage_if imem ();

  assign imem.imem_ready = zw ? imem.imem_req  : m_ready;
  assign imem.imem_rdata = zw ? imem.imem_addr : m_rdata;

  if_stage #(.RESET_PC(32'h0000_3000)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .pc_sel      (pc_sel),
    .npc_beq     (npc_beq),
    .npc_j       (npc_j),
    .npc_jr      (npc_jr),
    .imem        (imem.master),
    .if_id_pc    (if_id_pc),
    .if_id_pc4   (if_id_pc4),
    .if_id_instr (if_id_instr),
    .if_id_valid (if_id_valid),
    .dbg_state_o (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick();
    checks++; if (imem.imem_req !== 1'b0) $display("FAIL rst_req got %0b exp 0", imem.imem_req); else passed++;
    checks++; if (if_id_pc !== 32'd0) $display("FAIL rst_pc got %h exp 0", if_id_pc); else passed++;
    checks++; if (if_id_pc4 !== 32'd0) $display("FAIL rst_pc4 got %h exp 0", if_id_pc4); else passed++;
    checks++; if (if_id_instr !== 32'd0) $display("FAIL rst_instr got %h exp 0", if_id_instr); else passed++;
    checks++; if (if_id_valid !== 1'b0) $display("FAIL rst_valid got %0b exp 0", if_id_valid); else passed++;
    rst = 1'b0;
    #1;
    checks++; if (imem.imem_req !== 1'b1) $display("FAIL first_req got %0b exp 1", imem.imem_req); else passed++;
    checks++; if (imem.imem_addr !== 32'h3000) $display("FAIL first_addr got %h exp 3000", imem.imem_addr); else passed++;
  endtask

  task automatic test_sequential;
    logic [31:0] exp_pc;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_pc = 32'h3000 + 32'(4 * i);
      checks++; if (if_id_pc !== exp_pc) $display("FAIL seq_pc[%0d] got %h exp %h", i, if_id_pc, exp_pc); else passed++;
      checks++; if (if_id_pc4 !== exp_pc + 32'd4) $display("FAIL seq_pc4[%0d] got %h exp %h", i, if_id_pc4, exp_pc + 32'd4); else passed++;
      checks++; if (if_id_instr !== exp_pc) $display("FAIL seq_instr[%0d] got %h exp %h", i, if_id_instr, exp_pc); else passed++;
      checks++; if (if_id_valid !== 1'b1) $display("FAIL seq_valid[%0d] got %0b exp 1", i, if_id_valid); else passed++;
    end
  endtask

  task automatic test_stall;
    // fa = 3010, IF/ID holds 300C.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (if_id_pc !== 32'h300C) $display("FAIL stall_pc[%0d] got %h exp 300c", i, if_id_pc); else passed++;
      checks++; if (if_id_instr !== 32'h300C) $display("FAIL stall_instr[%0d] got %h exp 300c", i, if_id_instr); else passed++;
      checks++; if (imem.imem_req !== 1'b0) $display("FAIL stall_req[%0d] got %0b exp 0", i, imem.imem_req); else passed++;
    end
    stall = 1'b0;
    tick();
    checks++; if (if_id_pc !== 32'h3010) $display("FAIL release_pc got %h exp 3010", if_id_pc); else passed++;
    checks++; if (if_id_instr !== 32'h3010) $display("FAIL release_instr got %h exp 3010", if_id_instr); else passed++;
    checks++; if (if_id_valid !== 1'b1) $display("FAIL release_valid got %0b exp 1", if_id_valid); else passed++;
    checks++; if (imem.imem_addr !== 32'h3014) $display("FAIL release_addr got %h exp 3014", imem.imem_addr); else passed++;
    tick();
    checks++; if (if_id_pc !== 32'h3014) $display("FAIL after_release_pc got %h exp 3014", if_id_pc); else passed++;
  endtask

  task automatic test_jump;
    // fa = 3018
    pc_sel = 2'b10;
    npc_j  = 32'h0000_4000;
    tick();
    pc_sel = 2'b00;
    checks++; if (if_id_valid !== 1'b0) $display("FAIL j_valid got %0b exp 0", if_id_valid); else passed++;
    checks++; if (imem.imem_addr !== 32'h4000) $display("FAIL j_addr got %h exp 4000", imem.imem_addr); else passed++;
    tick();
    checks++; if (if_id_pc !== 32'h4000) $display("FAIL j_pc got %h exp 4000", if_id_pc); else passed++;
    checks++; if (if_id_valid !== 1'b1) $display("FAIL j_valid2 got %0b exp 1", if_id_valid); else passed++;
  endtask

  task automatic test_drain;
    // fa = 4004, request outstanding, memory slow.
    zw      = 1'b0;
    m_ready = 1'b0;
    pc_sel  = 2'b01;
    npc_beq = 32'h0000_5000;
    tick();
    pc_sel = 2'b00;
    checks++; if (if_id_valid !== 1'b0) $display("FAIL drain_valid got %0b exp 0", if_id_valid); else passed++;
    checks++; if (imem.imem_addr !== 32'h4004) $display("FAIL drain_addr got %h exp 4004", imem.imem_addr); else passed++;
    checks++; if (imem.imem_req !== 1'b1) $display("FAIL drain_req got %0b exp 1", imem.imem_req); else passed++;
    tick();
    checks++; if (imem.imem_addr !== 32'h4004) $display("FAIL drain_addr2 got %h exp 4004", imem.imem_addr); else passed++;
    m_ready = 1'b1;
    m_rdata = 32'hDEAD_BEEF;
    tick();
    checks++; if (if_id_valid !== 1'b0) $display("FAIL stale_valid got %0b exp 0", if_id_valid); else passed++;
    checks++; if (if_id_instr === 32'hDEAD_BEEF) $display("FAIL stale_instr got %h exp not deadbeef", if_id_instr); else passed++;
    checks++; if (imem.imem_addr !== 32'h5000) $display("FAIL beq_addr got %h exp 5000", imem.imem_addr); else passed++;
    m_rdata = 32'h1111_5000;
    tick();
    checks++; if (if_id_pc !== 32'h5000) $display("FAIL beq_pc got %h exp 5000", if_id_pc); else passed++;
    checks++; if (if_id_instr !== 32'h1111_5000) $display("FAIL beq_instr got %h exp 11115000", if_id_instr); else passed++;
    checks++; if (if_id_valid !== 1'b1) $display("FAIL beq_valid got %0b exp 1", if_id_valid); else passed++;
  endtask

  task automatic test_drain_latest;
    // fa = 5004
    m_ready = 1'b0;
    pc_sel  = 2'b01;
    npc_beq = 32'h0000_7000;
    tick();
    pc_sel = 2'b11;
    npc_jr = 32'h0000_7101;
    tick();
    pc_sel  = 2'b00;
    m_ready = 1'b1;
    m_rdata = 32'hBAD0_BAD0;
    tick();
    checks++; if (imem.imem_addr !== 32'h7100) $display("FAIL latest_addr got %h exp 7100", imem.imem_addr); else passed++;
    checks++; if (if_id_valid !== 1'b0) $display("FAIL latest_valid got %0b exp 0", if_id_valid); else passed++;
  endtask

  task automatic test_stall_redirect;
    // fa = 7100, ready=1
    stall  = 1'b1;
    pc_sel = 2'b11;
    npc_jr = 32'h0000_6002;
    tick();
    stall  = 1'b0;
    pc_sel = 2'b00;
    checks++; if (imem.imem_addr !== 32'h6000) $display("FAIL jr_addr got %h exp 6000", imem.imem_addr); else passed++;
    checks++; if (if_id_valid !== 1'b0) $display("FAIL jr_valid got %0b exp 0", if_id_valid); else passed++;
    checks++; if (imem.imem_req !== 1'b1) $display("FAIL jr_req got %0b exp 1", imem.imem_req); else passed++;
    m_rdata = 32'h2222_6000;
    tick();
    checks++; if (if_id_pc !== 32'h6000) $display("FAIL jr_pc got %h exp 6000", if_id_pc); else passed++;
    checks++; if (if_id_instr !== 32'h2222_6000) $display("FAIL jr_instr got %h exp 22226000", if_id_instr); else passed++;
  endtask

  task automatic test_bubble;
    // fa = 6004, IF/ID = 6000 valid
    m_ready = 1'b0;
    stall   = 1'b1;
    tick();
    checks++; if (if_id_valid !== 1'b1) $display("FAIL miss_stall_valid got %0b exp 1", if_id_valid); else passed++;
    checks++; if (if_id_pc !== 32'h6000) $display("FAIL miss_stall_pc got %h exp 6000", if_id_pc); else passed++;
    stall = 1'b0;
    tick();
    checks++; if (if_id_valid !== 1'b0) $display("FAIL bubble_valid got %0b exp 0", if_id_valid); else passed++;
    checks++; if (imem.imem_addr !== 32'h6004) $display("FAIL bubble_addr got %h exp 6004", imem.imem_addr); else passed++;
    m_ready = 1'b1;
    m_rdata = 32'h3333_6004;
    tick();
    checks++; if (if_id_pc !== 32'h6004) $display("FAIL after_bubble_pc got %h exp 6004", if_id_pc); else passed++;
    checks++; if (if_id_valid !== 1'b1) $display("FAIL after_bubble_valid got %0b exp 1", if_id_valid); else passed++;
  endtask

  task automatic test_reset_mid;
    // fa = 6008
    m_ready = 1'b0;
    pc_sel  = 2'b01;
    npc_beq = 32'h0000_8000;
    tick();
    pc_sel = 2'b00;
    checks++; if (dbg_state !== 2'd2) $display("FAIL pre_rst_state got %0d exp 2", dbg_state); else passed++;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (imem.imem_req !== 1'b0) $display("FAIL mid_rst_req got %0b exp 0", imem.imem_req); else passed++;
    checks++; if (if_id_pc !== 32'd0) $display("FAIL mid_rst_pc got %h exp 0", if_id_pc); else passed++;
    checks++; if (if_id_instr !== 32'd0) $display("FAIL mid_rst_instr got %h exp 0", if_id_instr); else passed++;
    checks++; if (imem.imem_addr !== 32'h3000) $display("FAIL mid_rst_addr got %h exp 3000", imem.imem_addr); else passed++;
    // Late response to the aborted fetch, arriving while reset is held.
    m_ready = 1'b1;
    m_rdata = 32'hBAD1_BAD1;
    tick();
    rst     = 1'b0;
    m_ready = 1'b0;
    #1;
    checks++; if (imem.imem_addr !== 32'h3000) $display("FAIL post_rst_addr got %h exp 3000", imem.imem_addr); else passed++;
    checks++; if (imem.imem_req !== 1'b1) $display("FAIL post_rst_req got %0b exp 1", imem.imem_req); else passed++;
    checks++; if (if_id_valid !== 1'b0) $display("FAIL post_rst_valid got %0b exp 0", if_id_valid); else passed++;
    zw = 1'b1;
    tick();
    checks++; if (if_id_pc !== 32'h3000) $display("FAIL post_rst_pc got %h exp 3000", if_id_pc); else passed++;
    checks++; if (if_id_instr !== 32'h3000) $display("FAIL post_rst_instr got %h exp 3000", if_id_instr); else passed++;
    checks++; if (if_id_valid !== 1'b1) $display("FAIL post_rst_valid2 got %0b exp 1", if_id_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_jump();
    test_drain();
    test_drain_latest();
    test_stall_redirect();
    test_bubble();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, the PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous and active-high.
REQ-004 stall  input  1  hazard unit request to hold the IF/ID register and the PC.
REQ-005 pc_sel  input  2  next-PC select from ID: 00 sequential, 01 npc_beq, 10 npc_j, 11 npc_jr; nonzero means redirect.
REQ-006 npc_beq, npc_j, npc_jr  input  32 each  redirect targets computed in ID.
REQ-007 imem_req  output  1  instruction fetch request.
REQ-008 imem_addr  output  32  fetch address, word aligned.
REQ-009 imem_ready  input  1  memory response valid; imem_rdata is sampled in the same cycle.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 if_id_pc, if_id_pc4, if_id_instr  output  32 each  IF/ID register: instruction PC, PC+4, instruction word.
REQ-012 if_id_valid  output  1  IF/ID holds a real instruction; 0 means bubble.

Function
REQ-013 Internal registers: fa (fetch address, 32), pend (pending target, 32), hold_instr (32), state in {FETCH, HOLD, DRAIN}.
REQ-014 Redirect target = the selected npc_* with bits [1:0] forced to 00; sequential next address = fa + 4, modulo 2^32 (wrap from 32'hFFFF_FFFC to 0).
REQ-015 Memory handshake: at most one request outstanding; imem_req=1 and imem_addr=fa in FETCH and DRAIN; imem_addr is stable until imem_ready; imem_req=0 in HOLD.
REQ-016 Redirect has priority over stall; when the redirect and the stall are both asserted, the stall is ignored for that cycle.
REQ-017 FETCH with imem_ready and redirect: if_id_valid<=0, fa<=target; stay in FETCH.
REQ-018 FETCH with imem_ready, stall, and no redirect: hold_instr<=imem_rdata; IF/ID and fa unchanged; go to HOLD.
REQ-019 FETCH with imem_ready, no stall, and no redirect: IF/ID<={fa, fa+4, imem_rdata, 1}, fa<=fa+4; stay in FETCH, so the next request is issued in the following cycle.
REQ-020 FETCH without imem_ready and with redirect: if_id_valid<=0, pend<=target; go to DRAIN.
REQ-021 FETCH without imem_ready and without redirect: if stall, IF/ID is held; otherwise if_id_valid<=0 (bubble inserted).
REQ-022 HOLD with redirect: if_id_valid<=0, fa<=target; go to FETCH.
REQ-023 HOLD with stall: all state is held.
REQ-024 HOLD with neither redirect nor stall: IF/ID<={fa, fa+4, hold_instr, 1}, fa<=fa+4; go to FETCH.
REQ-025 DRAIN: the outstanding response is discarded.
REQ-026 DRAIN: a new redirect overwrites pend, so the latest target wins.
REQ-027 DRAIN: if_id_valid stays 0.
REQ-028 DRAIN with imem_ready: fa<=pend; if a redirect arrives in the same cycle, its target is used instead; go to FETCH.
REQ-029 Whenever the IF/ID register is held, if_id_pc, if_id_pc4, if_id_instr and if_id_valid keep their values.
REQ-030 Latency: with imem_ready returned in the request cycle and no stall, one instruction enters IF/ID every cycle, one edge after the request.

Reset
REQ-031 While rst=1: fa=RESET_PC, pend=RESET_PC, hold_instr=0, state=FETCH, imem_req=0.
REQ-032 While rst=1: if_id_pc=0, if_id_pc4=0, if_id_instr=0, if_id_valid=0.
REQ-033 Assertion of rst mid-operation aborts any outstanding fetch; the response to that fetch is ignored.
REQ-034 The first request after rst deasserts goes to RESET_PC.

Verification
REQ-035 Zero-wait memory returning addr as data, no stall, no redirect for 4 cycles -> if_id_pc = 3000, 3004, 3008, 300C on consecutive edges; if_id_pc4 = if_id_pc+4; valid=1.
REQ-036 stall asserted for 3 cycles while memory is ready -> IF/ID frozen; imem_req=0 during HOLD; on release, the held instruction enters IF/ID, and no fetch is lost or duplicated.
REQ-037 pc_sel=10, npc_j=0000_4000, while the request is ready -> next IF/ID valid=0; next imem_addr=4000; then if_id_pc=4000.
REQ-038 Memory with 3-cycle latency, and pc_sel=01, npc_beq=0000_5000 in the first wait cycle -> DRAIN; the old response is discarded; next request goes to 5000; no stale instruction appears in IF/ID.
REQ-039 Simultaneous stall and pc_sel=11 with npc_jr=0000_6002 -> redirect wins; fetch goes to 6000; IF/ID valid=0.
REQ-040 rst pulse while a request is outstanding in DRAIN -> outputs go to reset values immediately; after release, the first imem_addr is RESET_PC.
